// File: rtl/adc_capture_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_capture_buffer_if
// Brief    : Sample stream, capture control, readout and status bundle.
// Revision : 1.0
// ============================================================================
interface adc_capture_buffer_if #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 14,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH*SAMPLE_W-1:0] adc_data;
    logic                       adc_valid;
    logic                       arm;
    logic                       force_trig;
    logic [CH_W-1:0]            trig_ch;
    logic [SAMPLE_W-1:0]        trig_level;
    logic                       trig_rising;
    logic [ADDR_W-1:0]          pretrig;
    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr;
    logic [CH_W-1:0]            rd_ch;
    logic [SAMPLE_W-1:0]        rd_data;
    logic                       rd_valid;
    logic                       busy;
    logic                       triggered;
    logic                       done;

    modport master (
        output adc_data, adc_valid, arm, force_trig, trig_ch, trig_level,
               trig_rising, pretrig, rd_en, rd_addr, rd_ch,
        input  rd_data, rd_valid, busy, triggered, done
    );

    modport slave (
        input  adc_data, adc_valid, arm, force_trig, trig_ch, trig_level,
               trig_rising, pretrig, rd_en, rd_addr, rd_ch,
        output rd_data, rd_valid, busy, triggered, done
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_capture_buffer
// Brief    : Multi-channel ADC snapshot buffer with level/forced trigger and
//            pre-trigger history, read back oldest-first.
// Revision : 1.0
// ============================================================================
module adc_capture_buffer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 14,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic            adc_clk,
    input  wire logic            rst_adc,
    adc_capture_buffer_if.slave  bus
);
    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_PRE  = 3'd1;
    localparam logic [2:0] C_ST_WAIT = 3'd2;
    localparam logic [2:0] C_ST_POST = 3'd3;
    localparam logic [2:0] C_ST_DONE = 3'd4;

    logic [2:0]                 r_state;
    logic [2:0]                 w_next;

    logic [CH_W-1:0]            r_trig_ch;
    logic signed [SAMPLE_W-1:0] r_level;
    logic                       r_rising;
    logic [ADDR_W-1:0]          r_pretrig;

    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [ADDR_W-1:0]          r_cnt;
    logic [ADDR_W-1:0]          r_remaining;
    logic [ADDR_W-1:0]          r_start_ptr;
    logic                       r_force;
    logic signed [SAMPLE_W-1:0] r_prev;
    logic                       r_prev_ok;

    logic                       r_busy;
    logic                       r_triggered;
    logic                       r_done;
    logic                       r_rd_valid;
    logic [SAMPLE_W-1:0]        r_rd_data;

    logic [NUM_CH*SAMPLE_W-1:0] r_mem [DEPTH];

    logic signed [SAMPLE_W-1:0] w_cur;
    logic                       w_rise;
    logic                       w_fall;
    logic                       w_edge;
    logic                       w_write;
    logic                       w_trig;
    logic [ADDR_W-1:0]          w_rem_init;
    logic [ADDR_W-1:0]          w_rd_phys;
    logic [NUM_CH*SAMPLE_W-1:0] w_rd_word;
    logic [SAMPLE_W-1:0]        w_rd_lane;

    // Lane muxes are loop-compared so out-of-range channel codes read as zero.
    always_comb begin
        w_cur = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(r_trig_ch) == k) w_cur = bus.adc_data[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    assign w_rise     = r_prev_ok && (r_prev < r_level) && (w_cur >= r_level);
    assign w_fall     = r_prev_ok && (r_prev > r_level) && (w_cur <= r_level);
    assign w_edge     = r_rising ? w_rise : w_fall;
    // DEPTH - pretrig - 1 is the bitwise complement within ADDR_W bits.
    assign w_rem_init = ~r_pretrig;

    always_ff @(posedge adc_clk or posedge rst_adc) begin
        if (rst_adc) r_state <= C_ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.arm) begin
            w_next = (bus.pretrig == '0) ? C_ST_WAIT : C_ST_PRE;
        end else begin
            case (r_state)
                C_ST_PRE:  if (bus.adc_valid && ((r_cnt + ADDR_W'(1)) == r_pretrig))
                               w_next = C_ST_WAIT;
                C_ST_WAIT: if (w_trig)
                               w_next = (w_rem_init == '0) ? C_ST_DONE : C_ST_POST;
                C_ST_POST: if (bus.adc_valid && (r_remaining == ADDR_W'(1)))
                               w_next = C_ST_DONE;
                default:   w_next = r_state;
            endcase
        end
    end

    // An arm in the same cycle suppresses both the write and any trigger.
    always_comb begin
        w_write = 1'b0;
        w_trig  = 1'b0;
        if (!bus.arm) begin
            case (r_state)
                C_ST_PRE, C_ST_POST: w_write = bus.adc_valid;
                C_ST_WAIT: begin
                    w_write = bus.adc_valid;
                    w_trig  = bus.adc_valid && (r_force || bus.force_trig || w_edge);
                end
                default: begin
                    w_write = 1'b0;
                    w_trig  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk or posedge rst_adc) begin
        if (rst_adc) begin
            r_trig_ch   <= '0;
            r_level     <= '0;
            r_rising    <= 1'b0;
            r_pretrig   <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_remaining <= '0;
            r_start_ptr <= '0;
            r_force     <= 1'b0;
            r_prev      <= '0;
            r_prev_ok   <= 1'b0;
            r_busy      <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_next == C_ST_PRE) || (w_next == C_ST_WAIT) || (w_next == C_ST_POST);
            r_done <= (r_state == C_ST_DONE) && !bus.arm;
            if (bus.arm) begin
                r_trig_ch   <= bus.trig_ch;
                r_level     <= bus.trig_level;
                r_rising    <= bus.trig_rising;
                r_pretrig   <= bus.pretrig;
                r_wr_ptr    <= '0;
                r_cnt       <= '0;
                r_force     <= 1'b0;
                r_prev_ok   <= 1'b0;
                r_triggered <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    if (r_state != C_ST_POST) begin
                        r_prev    <= w_cur;
                        r_prev_ok <= 1'b1;
                    end
                end
                if ((r_state == C_ST_PRE) && w_write) r_cnt <= r_cnt + ADDR_W'(1);
                if (((r_state == C_ST_PRE) || (r_state == C_ST_WAIT)) && bus.force_trig)
                    r_force <= 1'b1;
                if (w_trig) begin
                    r_start_ptr <= r_wr_ptr - r_pretrig;
                    r_triggered <= 1'b1;
                    r_remaining <= w_rem_init;
                end else if ((r_state == C_ST_POST) && w_write) begin
                    r_remaining <= r_remaining - ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (w_write) r_mem[r_wr_ptr] <= bus.adc_data;
    end

    assign w_rd_phys = r_start_ptr + bus.rd_addr;
    assign w_rd_word = r_mem[w_rd_phys];

    always_comb begin
        w_rd_lane = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(bus.rd_ch) == k) w_rd_lane = w_rd_word[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge adc_clk or posedge rst_adc) begin
        if (rst_adc) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_data <= w_rd_lane;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.busy      = r_busy;
    assign bus.triggered = r_triggered;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Parametrised multi-channel ADC snapshot buffer with level trigger and pre-trigger history, in the `adc_clk` domain after the ADC deserialiser. It replaces fixed-width, fixed-channel debug capture with a software-armed, software-readable capture of `NUM_CH` channels × `DEPTH` samples. It provides rising/falling/forced triggering and time-ordered readout.

## Interface
- `NUM_CH`, default 4: number of ADC channels (≥1)
- `SAMPLE_W`, default 14: bits per sample, two's complement
- `DEPTH`, default 1024: samples per channel, power of 2, ≥4
- `ADDR_W`, default $clog2(DEPTH): derived, not overridden
- `CH_W`, default max(1,$clog2(NUM_CH)): derived
- `adc_clk`  in  1  sole clock
- `rst_adc`  in  1  reset, asynchronous, active-high
- `adc_data`  in  NUM_CH*SAMPLE_W  channel k at [k*SAMPLE_W +: SAMPLE_W]
- `adc_valid`  in  1  adc_data holds a new sample set this cycle
- `arm`  in  1  single-cycle pulse: latch settings, start capture
- `force_trig`  in  1  single-cycle pulse: software trigger
- `trig_ch`  in  CH_W  trigger source channel (latched at arm)
- `trig_level`  in  SAMPLE_W  signed threshold (latched at arm)
- `trig_rising`  in  1  1 rising, 0 falling (latched at arm)
- `pretrig`  in  ADDR_W  samples kept before trigger sample (latched at arm)
- `rd_en`, `rd_addr` (ADDR_W), `rd_ch` (CH_W)  in  readout request; rd_addr 0 = oldest sample
- `rd_data`  out  SAMPLE_W  read sample
- `rd_valid`  out  1  rd_data valid
- `busy`, `triggered`, `done`  out  1 each  status

## Operation
- Storage: one RAM, DEPTH words × NUM_CH*SAMPLE_W; write pointer `wr_ptr` (ADDR_W, wraps mod DEPTH); writes occur only on adc_valid in PRE/WAIT_TRIG/POST.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- IDLE: on arm → latch settings, wr_ptr=0, cnt=0, clear triggered, force flag, prev_ok → PRE (WAIT_TRIG if pretrig=0).
- PRE: each valid sample written, cnt++; when cnt reaches pretrig → WAIT_TRIG. Trigger conditions ignored; force_trig sets sticky force flag.
- WAIT_TRIG: each valid sample written (wrap overwrites oldest). Trigger on a valid sample if force flag set, force_trig this cycle, or edge: rising = prev_ok & prev < level & cur ≥ level; falling = prev_ok & prev > level & cur ≤ level (signed compare, cur = trig_ch sample, prev = previous valid trig_ch sample since arm). prev/prev_ok update on every written sample in PRE and WAIT_TRIG.
- On trigger: sample written; start_ptr = wr_ptr − pretrig mod DEPTH; triggered=1; remaining = DEPTH − pretrig − 1; → POST, or DONE if remaining=0.
- POST: each valid sample written, remaining--; after last → DONE.
- DONE: done=1; holds until arm (→ PRE/WAIT_TRIG as from IDLE).
- arm in any busy state: abort and restart as from IDLE; done, triggered cleared.
- Readout: physical address = start_ptr + rd_addr mod DEPTH; rd_ch selects lane. Trigger sample at rd_addr = pretrig. Permitted in any state; data defined only in DONE.
- busy = state ∈ {PRE, WAIT_TRIG, POST}.

## Timing
- Reset values: state IDLE, busy 0, triggered 0, done 0, rd_valid 0, rd_data 0, wr_ptr 0; RAM contents not cleared.
- rst_adc asserted mid-capture: outputs to reset values immediately (asynchronous), capture abandoned.
- All status outputs registered; triggered and state change on the clock edge sampling the trigger sample; done rises the edge after the last write.
- Read latency 1: rd_en at edge N → rd_data/rd_valid valid after edge N+1; rd_valid 0 otherwise; back-to-back reads every cycle.
- adc_valid gaps stall all counters; no sample dropped or duplicated.
- arm and trigger same cycle: arm wins, sample not treated as trigger.

## Test plan
- DEPTH=16, NUM_CH=2, pretrig=4, ch0 ramp 0,1,2…, level=10 rising → trigger at sample 10; done after sample 21; rd_addr 0..15 ch0 = 6..21, rd_addr 4 = 10, rd_valid one cycle after rd_en.
- ch1 100 down to −100 step −10, level=−5 falling, adc_valid every 3rd cycle → trigger sample −10; rd_addr pretrig ch1 = −10; rd_addr 0 ch1 = −10 + 10·pretrig.
- Crossing during PRE (ramp crosses at sample 2, pretrig=4) → no trigger; next crossing triggers. force_trig with flat input, pretrig=0 → first valid sample after force at rd_addr 0.
- pretrig=15 (DEPTH−1) → done one cycle after trigger, trigger sample at rd_addr 15.
- arm pulsed during POST → triggered and done drop, capture restarts; rst_adc during WAIT_TRIG → busy/triggered/done 0 immediately, re-arm works.
- Trigger held in WAIT_TRIG long enough to wrap wr_ptr ≥2× → readout still shows exactly the pretrig samples preceding the trigger in order.
